// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and helpers for the UART packet path.
package uart_pkg;

  localparam int CLK_F_DEF  = 50000000;
  localparam int UART_B_DEF = 115200;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  function automatic int b_cnt(input int clk_f, input int baud);
    return clk_f / baud;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with combinational head read and a tail-MSB set port
// used to mark the final byte of a packet after it was written.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_set_last,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata,
  output logic [clog2(DEPTH):0] o_fill
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_fill;
  logic [AW-1:0]    w_tail;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  assign w_tail  = r_wr - AW'(1);
  assign w_full  = (r_fill == (AW+1)'(DEPTH));
  assign w_wr    = i_push & (~w_full | i_pop);
  assign w_rd    = i_pop & (r_fill != '0);
  assign o_rdata = r_mem[r_rd];
  assign o_fill  = r_fill;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
    end else if (i_flush) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_rd) r_rd <= r_rd + AW'(1);
      if (i_set_last) r_mem[w_tail][WIDTH-1] <= 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + (AW+1)'(1);
        2'b01:   r_fill <= r_fill - (AW+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Sequences the UART receiver enable and packetises its bytes,
// closing a packet after an inter-byte silence timeout.
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_F     = CLK_F_DEF,
  parameter int UART_B    = UART_B_DEF,
  parameter int IDLE_BITS = 20,
  parameter int DEPTH     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_rx_busy,
  output logic                  o_rx_en,
  output logic [7:0]            o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_m_last,
  output logic [clog2(DEPTH):0] o_fill,
  output logic                  o_overrun
);

  localparam int AW    = clog2(DEPTH);
  localparam int B_CNT = b_cnt(CLK_F, UART_B);
  localparam int TMO   = IDLE_BITS * B_CNT;
  localparam int CW    = clog2(TMO + 1);

  logic [1:0]    r_state;
  logic          r_done_q;
  logic          r_open;
  logic          r_ovr;
  logic [CW-1:0] r_cnt;

  logic          w_evt;
  logic          w_rx_act;
  logic          w_push;
  logic          w_full;
  logic          w_pop;
  logic          w_push_acc;
  logic          w_drop;
  logic          w_tmo;
  logic          w_fclose;
  logic          w_close;
  logic [AW:0]   w_fill;
  logic [8:0]    w_head;

  assign w_evt    = i_rx_done & ~r_done_q;
  assign w_rx_act = (r_state == ST_RUN) | (r_state == ST_DRAIN);
  assign w_push   = w_evt & w_rx_act;
  assign w_full   = (w_fill == (AW+1)'(DEPTH));

  // Newest byte of an open packet stays hidden until its last bit is known
  assign o_m_valid = (w_fill >= (AW+1)'(2))
                   | ((w_fill == (AW+1)'(1)) & ~r_open);

  assign w_pop      = o_m_valid & i_m_ready & ~i_flush;
  assign w_push_acc = w_push & ~i_flush & (~w_full | w_pop);
  assign w_drop     = w_push & ~i_flush & w_full & ~w_pop;

  assign w_tmo = r_open & ~w_push_acc & ~i_rx_busy
               & (r_cnt == CW'(TMO - 1));
  assign w_fclose = (r_state == ST_DRAIN) & ~i_rx_busy & ~w_evt;
  assign w_close  = (w_tmo | w_fclose) & r_open & ~i_flush;

  assign o_rx_en = (r_state == ST_ARM)
                 | (r_state == ST_RUN)
                 | ((r_state == ST_DRAIN) & (i_rx_busy | w_evt));

  assign o_m_data  = w_head[7:0];
  assign o_m_last  = w_head[8];
  assign o_fill    = w_fill;
  assign o_overrun = r_ovr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_OFF;
    end else begin
      unique case (r_state)
        ST_OFF:   if (i_enable) r_state <= ST_ARM;
        ST_ARM:   r_state <= ST_RUN;
        ST_RUN:   if (!i_enable) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_fclose) r_state <= ST_OFF;
        default:  r_state <= ST_OFF;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done_q <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_done_q <= i_rx_done;
      if (w_drop) r_ovr <= 1'b1;
      else if (i_clr_err) r_ovr <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_open <= 1'b0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_open <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_push_acc) r_open <= 1'b1;
      else if (w_close) r_open <= 1'b0;
      if (w_push_acc | i_rx_busy | w_close) r_cnt <= '0;
      else if (r_open) r_cnt <= r_cnt + CW'(1);
    end
  end

  uart_sync_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_flush    (i_flush),
    .i_push     (w_push_acc),
    .i_pop      (w_pop),
    .i_set_last (w_close),
    .i_wdata    ({1'b0, i_rx_data}),
    .o_rdata    (w_head),
    .o_fill     (w_fill)
  );

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed/random bench for uart_rx_pkt_ctrl against a queue-based
// packet model.
module tb_uart_rx_pkt_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = (50000000 / 115200) * 20;

  localparam int M_OFF = 0;
  localparam int M_ARM = 1;
  localparam int M_RUN = 2;
  localparam int M_DRN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_busy = 1'b0;
  logic       m_ready = 1'b0;
  logic       rx_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic [2:0] fill;
  logic       ovr;

  int n_chk = 0;
  int n_fail = 0;

  logic [8:0] q[$];
  logic [8:0] got[$];
  logic [8:0] exp_q[$];
  bit         m_open;
  int         m_cnt;
  int         m_st;
  bit         m_ovr;
  bit         m_pdone;
  bit         tog = 0;
  bit         p_stall = 0;
  logic [8:0] p_head;

  always #5 clk = ~clk;

  uart_rx_pkt_ctrl #(
    .DEPTH (DEPTH)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_enable  (enable),
    .i_flush   (flush),
    .i_clr_err (clr_err),
    .i_rx_data (rx_data),
    .i_rx_done (rx_done),
    .i_rx_busy (rx_busy),
    .o_rx_en   (rx_en),
    .o_m_data  (m_data),
    .o_m_valid (m_valid),
    .i_m_ready (m_ready),
    .o_m_last  (m_last),
    .o_fill    (fill),
    .o_overrun (ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_open = 0;
    m_cnt = 0;
    m_st = M_OFF;
    m_ovr = 0;
    m_pdone = 0;
  endtask

  // One clock: check outputs at negedge, advance model at posedge.
  task automatic step();
    bit evt, valid, pop, push, acc, fclose, close, en;
    logic [8:0] t;
    @(negedge clk);
    if (!rst_n) model_reset();
    evt = rx_done && !m_pdone;
    valid = q.size() >= 2 || (q.size() == 1 && !m_open);
    en = (m_st == M_ARM) || (m_st == M_RUN) ||
         (m_st == M_DRN && (rx_busy || evt));
    chk("rx_en", rx_en, en);
    chk("fill", fill, q.size());
    chk("valid", m_valid, valid);
    chk("overrun", ovr, m_ovr);
    if (valid) chk("head", {m_last, m_data}, q[0]);
    if (p_stall && m_valid) chk("stable", {m_last, m_data}, p_head);
    p_stall = m_valid && !m_ready;
    p_head = {m_last, m_data};
    if (m_valid && m_ready) got.push_back({m_last, m_data});
    @(posedge clk);
    if (rst_n) begin
      pop = valid && m_ready && !flush;
      push = evt && (m_st == M_RUN || m_st == M_DRN);
      fclose = (m_st == M_DRN) && !rx_busy && !evt;
      close = 0;
      if (flush) begin
        q.delete();
        m_open = 0;
        m_cnt = 0;
        if (clr_err) m_ovr = 0;
      end else begin
        acc = push && (q.size() < DEPTH || pop);
        if (pop) void'(q.pop_front());
        if (acc) begin
          q.push_back({1'b0, rx_data});
          m_open = 1;
        end
        if (push && !acc) m_ovr = 1;
        else if (clr_err) m_ovr = 0;
        if (acc || rx_busy) m_cnt = 0;
        else if (m_open) begin
          m_cnt++;
          if (m_cnt == TMO) close = 1;
        end
        if (fclose && m_open) close = 1;
        if (close && q.size() > 0) begin
          t = q[q.size()-1];
          t[8] = 1'b1;
          q[q.size()-1] = t;
          m_open = 0;
          m_cnt = 0;
        end
      end
      case (m_st)
        M_OFF: if (enable) m_st = M_ARM;
        M_ARM: m_st = M_RUN;
        M_RUN: if (!enable) m_st = M_DRN;
        default: if (fclose) m_st = M_OFF;
      endcase
      m_pdone = rx_done;
    end
    #1;
    if (tog) m_ready = !m_ready;
  endtask

  task automatic send_byte(input logic [7:0] d, input int nbusy);
    rx_busy = 1;
    repeat (nbusy) step();
    rx_busy = 0;
    rx_data = d;
    rx_done = 1;
    step();
    rx_done = 0;
    step();
  endtask

  task automatic wait_got(input int n, input int bound, output int cyc);
    cyc = 0;
    while (got.size() < n && cyc < bound) begin
      step();
      cyc++;
    end
  endtask

  task automatic cmp_got(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    if (got.size() == exp_q.size())
      foreach (exp_q[i]) chk(tag, got[i], exp_q[i]);
  endtask

  initial begin
    int cyc;
    logic [7:0] b;
    logic o;

    // 1: reset with enable held high, then ARM -> RUN
    enable = 1;
    repeat (3) step();
    chk("rst_data", m_data, 8'h00);
    chk("rst_last", m_last, 1'b0);
    chk("rst_rx_en", rx_en, 1'b0);
    rst_n = 1;
    chk("off_rx_en", rx_en, 1'b0);
    step();
    chk("arm_rx_en", rx_en, 1'b1);
    step();
    chk("run_rx_en", rx_en, 1'b1);

    // 2: three bytes, last one released by the silence timeout
    m_ready = 1;
    got.delete();
    send_byte(8'h55, 20);
    send_byte(8'hA3, 20);
    send_byte(8'h0F, 20);
    chk("t2_early", got.size(), 2);
    wait_got(3, TMO + 100, cyc);
    chk("t2_hold_lo", cyc >= TMO - 4, 1);
    chk("t2_hold_hi", cyc <= TMO + 4, 1);
    exp_q = '{9'h055, 9'h0A3, 9'h10F};
    cmp_got("t2_bytes");

    // 3: overrun with ready low, clear, then drain
    m_ready = 0;
    got.delete();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 4);
    chk("t3_fill", fill, 3'd4);
    chk("t3_ovr", ovr, 1'b1);
    clr_err = 1;
    step();
    clr_err = 0;
    step();
    chk("t3_clr", ovr, 1'b0);
    m_ready = 1;
    wait_got(4, TMO + 100, cyc);
    exp_q = '{9'h001, 9'h002, 9'h003, 9'h104};
    cmp_got("t3_bytes");

    // 4: random bytes with ready toggling every cycle
    got.delete();
    exp_q.delete();
    m_ready = 0;
    tog = 1;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back({i == 3, b});
      send_byte(b, $urandom_range(3, 15));
      repeat ($urandom_range(0, 30)) step();
    end
    wait_got(4, TMO + 200, cyc);
    tog = 0;
    m_ready = 1;
    step();
    cmp_got("t4_bytes");

    // 5: disable mid-frame; drain finishes the byte and closes the packet
    got.delete();
    rx_busy = 1;
    repeat (3) step();
    enable = 0;
    repeat (5) step();
    chk("t5_rx_en_busy", rx_en, 1'b1);
    rx_busy = 0;
    rx_data = 8'hC3;
    rx_done = 1;
    step();
    rx_done = 0;
    wait_got(1, 20, cyc);
    exp_q = '{9'h1C3};
    cmp_got("t5_bytes");
    step();
    chk("t5_rx_en_off", rx_en, 1'b0);
    step();
    chk("t5_stay_off", rx_en, 1'b0);

    // 6: flush coincident with a byte event at FILL=3
    enable = 1;
    repeat (2) step();
    m_ready = 0;
    got.delete();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 4);
    chk("t6_fill3", fill, 3'd3);
    o = ovr;
    rx_data = 8'h99;
    rx_done = 1;
    flush = 1;
    step();
    flush = 0;
    rx_done = 0;
    chk("t6_fill0", fill, 3'd0);
    chk("t6_valid0", m_valid, 1'b0);
    chk("t6_ovr", ovr, o);
    m_ready = 1;
    repeat (20) step();
    chk("t6_none", got.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
